cmp_share_arbiter: RTL and testbench

//  Shares one comparator_lt instance between two requesters: port 0 = branch unit
//  (BLT/BGE/BLTU/BGEU), port 1 = ALU SLT/SLTI/SLTU/SLTIU path.
//  - Round-robin arbitration, one comparison per cycle.
//  - Valid/ready on requests; result held in a 1-entry registered response buffer

---
 rtl/cmp_share_arbiter.sv | 128 ++++++++++++
 tb/tb_cmp_share_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/cmp_share_arbiter.sv
// Shared less-than comparator with a round-robin front end and a
// single registered response slot for the branch unit and the ALU.

module comparator_lt #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sel_signed,
  output logic         lt
);
  // sel_signed carries the requester's uns bit: 1 = magnitude compare
  always_comb begin
    lt = 1'b0;
    if (sel_signed) lt = (a < b);
    else            lt = ($signed(a) < $signed(b));
  end
endmodule

module cmp_share_arbiter #(
  parameter int       N       = 32,
  parameter bit [0:0] RR_INIT = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_flush,
  input  logic [1:0]   i_req_valid,
  output logic [1:0]   o_req_ready,
  input  logic [N-1:0] i_req0_a,
  input  logic [N-1:0] i_req0_b,
  input  logic         i_req0_uns,
  input  logic [N-1:0] i_req1_a,
  input  logic [N-1:0] i_req1_b,
  input  logic         i_req1_uns,
  output logic [1:0]   o_rsp_valid,
  input  logic [1:0]   i_rsp_ready,
  output logic         o_rsp_lt
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   lt_q, lt_d;
  logic   rr_q, rr_d;

  logic         can_grant;
  logic         sel;
  logic         accept;
  logic [N-1:0] mux_a, mux_b;
  logic         mux_uns;
  logic         cmp_lt;

  // Slot can take a new request when empty or being drained this cycle
  always_comb begin
    can_grant = 1'b0;
    if (!i_reset && !i_flush)
      can_grant = (state_q == EMPTY) || i_rsp_ready[owner_q];
  end

  // Pick the port to offer: the lone valid one, else the rr pointer
  always_comb begin
    sel = rr_q;
    unique case (1'b1)
      (i_req_valid == 2'b01): sel = 1'b0;
      (i_req_valid == 2'b10): sel = 1'b1;
      default:                sel = rr_q;
    endcase
    o_req_ready = 2'b00;
    if (can_grant) o_req_ready = sel ? 2'b10 : 2'b01;
    accept = |(i_req_valid & o_req_ready);
  end

  // Operand and signedness mux follows the selected port
  always_comb begin
    mux_a   = sel ? i_req1_a   : i_req0_a;
    mux_b   = sel ? i_req1_b   : i_req0_b;
    mux_uns = sel ? i_req1_uns : i_req0_uns;
  end

  comparator_lt #(.N(N)) u_cmp (
    .a          (mux_a),
    .b          (mux_b),
    .sel_signed (mux_uns),
    .lt         (cmp_lt)
  );

  // Response slot next state; flush wins over consume and accept
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    lt_d    = lt_q;
    rr_d    = rr_q;
    if (i_flush) begin
      state_d = EMPTY;
    end else if (accept) begin
      state_d = FULL;
      owner_d = sel;
      lt_d    = cmp_lt;
      rr_d    = ~sel;
    end else if (state_q == FULL && i_rsp_ready[owner_q]) begin
      state_d = EMPTY;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= EMPTY;
      owner_q <= 1'b0;
      lt_q    <= 1'b0;
      rr_q    <= RR_INIT;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      lt_q    <= lt_d;
      rr_q    <= rr_d;
    end
  end

  // One-hot response valid decoded from the registered owner
  always_comb begin
    o_rsp_valid = 2'b00;
    if (state_q == FULL) o_rsp_valid = owner_q ? 2'b10 : 2'b01;
    o_rsp_lt = lt_q;
  end

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed bench for cmp_share_arbiter: arbitration order, latency,
// back-pressure, flush and reset behaviour against hand-computed values.

module tb_cmp_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] a0, b0, a1, b1;
  logic        uns0, uns1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic        rsp_lt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cmp_share_arbiter #(.N(32), .RR_INIT(1'b0)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_flush     (flush),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req0_a    (a0),
    .i_req0_b    (b0),
    .i_req0_uns  (uns0),
    .i_req1_a    (a1),
    .i_req1_b    (b1),
    .i_req1_uns  (uns1),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_lt    (rsp_lt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 2'b00; rsp_ready = 2'b11;
    a0 = '0; b0 = '0; uns0 = 1'b0;
    a1 = '0; b1 = '0; uns1 = 1'b0;
    tick(); tick();
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_lt", {31'd0, rsp_lt}, 32'd0);
    req_valid = 2'b11; #1;
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    req_valid = 2'b00;
    rst = 1'b0;
    tick();

    // T1: port0 signed -1 < 1
    a0 = 32'hFFFF_FFFF; b0 = 32'd1; uns0 = 1'b0; req_valid = 2'b01; #1;
    chk("t1_ready", {30'd0, req_ready}, 32'd1);
    tick();
    chk("t1_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    chk("t1_lt", {31'd0, rsp_lt}, 32'd1);

    // T2: port1 unsigned FFFFFFFF < 1 is false
    a1 = 32'hFFFF_FFFF; b1 = 32'd1; uns1 = 1'b1; req_valid = 2'b10; #1;
    chk("t2_ready", {30'd0, req_ready}, 32'd2);
    tick();
    chk("t2_rsp_valid", {30'd0, rsp_valid}, 32'd2);
    chk("t2_lt", {31'd0, rsp_lt}, 32'd0);
    a1 = 32'h8000_0000; b1 = 32'h8000_0000;
    tick();
    chk("t2_eq_rsp_valid", {30'd0, rsp_valid}, 32'd2);
    chk("t2_eq_lt", {31'd0, rsp_lt}, 32'd0);
    // signed min vs max
    a0 = 32'h8000_0000; b0 = 32'h7FFF_FFFF; uns0 = 1'b0; req_valid = 2'b01;
    tick();
    chk("t2_min_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    chk("t2_min_lt", {31'd0, rsp_lt}, 32'd1);
    req_valid = 2'b00;
    tick();
    chk("drain_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("drain_lt_held", {31'd0, rsp_lt}, 32'd1);

    // T4: port0 response stalled, port1 waiting
    a0 = 32'd1; b0 = 32'd2; uns0 = 1'b0; req_valid = 2'b01;
    tick();
    chk("t4_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    rsp_ready = 2'b10; req_valid = 2'b10;
    a1 = 32'd7; b1 = 32'd7; uns1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_stall_ready", {30'd0, req_ready}, 32'd0);
      chk("t4_stall_rsp", {30'd0, rsp_valid}, 32'd1);
      chk("t4_stall_lt", {31'd0, rsp_lt}, 32'd1);
      tick();
    end
    rsp_ready = 2'b11; #1;
    chk("t4_consume_ready", {30'd0, req_ready}, 32'd2);
    tick();
    chk("t4_p1_rsp", {30'd0, rsp_valid}, 32'd2);
    chk("t4_p1_lt", {31'd0, rsp_lt}, 32'd0);

    // T5: flush with buffer full and port1 valid
    a1 = 32'd0; b1 = 32'd1; uns1 = 1'b0;
    flush = 1'b1; #1;
    chk("t5_flush_ready", {30'd0, req_ready}, 32'd0);
    tick();
    flush = 1'b0; #1;
    chk("t5_rsp_cleared", {30'd0, rsp_valid}, 32'd0);
    chk("t5_lt_kept", {31'd0, rsp_lt}, 32'd0);
    chk("t5_ready_after", {30'd0, req_ready}, 32'd2);
    tick();
    chk("t5_p1_rsp", {30'd0, rsp_valid}, 32'd2);
    chk("t5_p1_lt", {31'd0, rsp_lt}, 32'd1);

    // T6: reset while full with both valid
    a0 = 32'd5; b0 = 32'd3; uns0 = 1'b0;
    a1 = 32'd3; b1 = 32'd5; uns1 = 1'b1;
    req_valid = 2'b11; rst = 1'b1; #1;
    chk("t6_rst_ready", {30'd0, req_ready}, 32'd0);
    tick();
    chk("t6_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("t6_lt", {31'd0, rsp_lt}, 32'd0);
    rst = 1'b0; #1;
    chk("t6_first_grant", {30'd0, req_ready}, 32'd1);

    // T3: both valid every cycle, alternating with no bubble
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_ready", {30'd0, req_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      chk("t3_rsp_valid", {30'd0, rsp_valid}, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("t3_lt", {31'd0, rsp_lt}, (i % 2 == 0) ? 32'd0 : 32'd1);
    end
    req_valid = 2'b00;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
